// File: rtl/tm1638_responder.sv
// TM1638 bus responder: decodes data/display/address commands, holds the
// 16-byte display RAM, shifts key bytes back. Option: TM1638_RESP_KEY_LATCH_EN.
module tm1638_responder #(
  parameter int         SYNC_STAGES   = 2,
  parameter logic [2:0] DEFAULT_LEVEL = 3'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tm_stb,
  input  logic       tm_clk,
  input  logic       tm_dio_in,
  output logic       tm_dio_oe,
  input  logic [7:0] keys,
  input  logic [3:0] ram_rd_addr,
  output logic [7:0] ram_rd_data,
  output logic       display_on,
  output logic [2:0] display_level,
  output logic       cmd_valid,
  output logic [7:0] cmd_byte,
  output logic       proto_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_WRITE, S_READ, S_DISC
  } state_t;

  logic [SYNC_STAGES-1:0] stb_sync_q, clk_sync_q, dio_sync_q;
  logic stb_prev_q, clk_prev_q;
  logic stb_s, clk_s, dio_s;
  logic stb_rise, stb_fall, clk_rise, clk_fall;

  state_t state_q, state_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [6:0] shreg_q, shreg_d;
  logic [3:0] ptr_q, ptr_d;
  logic rd_mode_q, rd_mode_d;
  logic fixed_q, fixed_d;
  logic on_q, on_d;
  logic [2:0] level_q, level_d;
  logic [7:0] cmd_byte_q, cmd_byte_d;
  logic cmd_valid_q, cmd_valid_d;
  logic proto_err_q, proto_err_d;
  logic oe_q, oe_d;
  logic [4:0] rd_idx_q, rd_idx_d;
  logic first_q, first_d;
  logic [7:0] ram_q [16];
  logic [7:0] rd_data_q;
  logic we;
  logic [7:0] byte_w;
  logic [31:0] kv;
  logic first_bit, next_bit;

  // Synchronizers and one-flop edge detectors (bus idles high)
  always_ff @(posedge clk) begin
    if (rst) begin
      stb_sync_q <= '1;
      clk_sync_q <= '1;
      dio_sync_q <= '1;
      stb_prev_q <= 1'b1;
      clk_prev_q <= 1'b1;
    end else begin
      stb_sync_q <= {stb_sync_q[SYNC_STAGES-2:0], tm_stb};
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], tm_clk};
      dio_sync_q <= {dio_sync_q[SYNC_STAGES-2:0], tm_dio_in};
      stb_prev_q <= stb_s;
      clk_prev_q <= clk_s;
    end
  end

  assign stb_s    = stb_sync_q[SYNC_STAGES-1];
  assign clk_s    = clk_sync_q[SYNC_STAGES-1];
  assign dio_s    = dio_sync_q[SYNC_STAGES-1];
  assign stb_rise = stb_s & ~stb_prev_q;
  assign stb_fall = ~stb_s & stb_prev_q;
  assign clk_rise = clk_s & ~clk_prev_q;
  assign clk_fall = ~clk_s & clk_prev_q;
  assign byte_w   = {dio_s, shreg_q};

  assign kv = {3'b0, keys[7], 3'b0, keys[6],
               3'b0, keys[5], 3'b0, keys[4],
               3'b0, keys[3], 3'b0, keys[2],
               3'b0, keys[1], 3'b0, keys[0]};

`ifdef TM1638_RESP_KEY_LATCH_EN
  logic [31:0] key_sr_q, key_sr_d;
  assign first_bit = key_sr_q[0];
  assign next_bit  = key_sr_q[1];
`else
  assign first_bit = kv[0];
  assign next_bit  = kv[rd_idx_q + 5'd1];
`endif

  // Bus FSM: next state, RAM write strobe and register updates
  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shreg_d     = shreg_q;
    ptr_d       = ptr_q;
    rd_mode_d   = rd_mode_q;
    fixed_d     = fixed_q;
    on_d        = on_q;
    level_d     = level_q;
    cmd_byte_d  = cmd_byte_q;
    cmd_valid_d = 1'b0;
    proto_err_d = 1'b0;
    oe_d        = oe_q;
    rd_idx_d    = rd_idx_q;
    first_d     = first_q;
    we          = 1'b0;
`ifdef TM1638_RESP_KEY_LATCH_EN
    key_sr_d    = key_sr_q;
`endif
    if (stb_rise) begin
      if ((state_q == S_CMD || state_q == S_WRITE) && bitcnt_q != 3'd0)
        proto_err_d = 1'b1;
      state_d  = S_IDLE;
      bitcnt_d = 3'd0;
      oe_d     = 1'b0;
      first_d  = 1'b0;
    end else if (stb_fall) begin
      state_d  = S_CMD;
      bitcnt_d = 3'd0;
    end else begin
      unique case (state_q)
        S_CMD, S_WRITE: begin
          if (clk_rise) begin
            shreg_d  = byte_w[7:1];
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7 && state_q == S_WRITE) begin
              we = 1'b1;
              if (!fixed_q) ptr_d = ptr_q + 4'd1;
            end else if (bitcnt_q == 3'd7) begin
              cmd_valid_d = 1'b1;
              cmd_byte_d  = byte_w;
              unique case (byte_w[7:6])
                2'b01: begin
                  rd_mode_d = byte_w[1];
                  fixed_d   = byte_w[2];
                  if (byte_w[1]) begin
                    state_d  = S_READ;
                    rd_idx_d = 5'd0;
                    first_d  = 1'b1;
`ifdef TM1638_RESP_KEY_LATCH_EN
                    key_sr_d = kv;
`endif
                  end
                end
                2'b10: begin
                  on_d    = byte_w[3];
                  level_d = byte_w[2:0];
                end
                2'b11: begin
                  ptr_d = byte_w[3:0];
                  if (rd_mode_q) begin
                    proto_err_d = 1'b1;
                    state_d     = S_DISC;
                  end else begin
                    state_d = S_WRITE;
                  end
                end
                default: begin
                  proto_err_d = 1'b1;
                  state_d     = S_DISC;
                end
              endcase
            end
          end
        end
        S_READ: begin
          if (first_q) begin
            first_d = 1'b0;
            oe_d    = ~first_bit;
          end else if (clk_fall) begin
            if (rd_idx_q == 5'd31) begin
              oe_d    = 1'b0;
              state_d = S_DISC;
            end else begin
              rd_idx_d = rd_idx_q + 5'd1;
              oe_d     = ~next_bit;
`ifdef TM1638_RESP_KEY_LATCH_EN
              key_sr_d = key_sr_q >> 1;
`endif
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Control/state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bitcnt_q    <= 3'd0;
      shreg_q     <= 7'd0;
      ptr_q       <= 4'd0;
      rd_mode_q   <= 1'b0;
      fixed_q     <= 1'b0;
      on_q        <= 1'b0;
      level_q     <= DEFAULT_LEVEL;
      cmd_byte_q  <= 8'd0;
      cmd_valid_q <= 1'b0;
      proto_err_q <= 1'b0;
      oe_q        <= 1'b0;
      rd_idx_q    <= 5'd0;
      first_q     <= 1'b0;
`ifdef TM1638_RESP_KEY_LATCH_EN
      key_sr_q    <= 32'd0;
`endif
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shreg_q     <= shreg_d;
      ptr_q       <= ptr_d;
      rd_mode_q   <= rd_mode_d;
      fixed_q     <= fixed_d;
      on_q        <= on_d;
      level_q     <= level_d;
      cmd_byte_q  <= cmd_byte_d;
      cmd_valid_q <= cmd_valid_d;
      proto_err_q <= proto_err_d;
      oe_q        <= oe_d;
      rd_idx_q    <= rd_idx_d;
      first_q     <= first_d;
`ifdef TM1638_RESP_KEY_LATCH_EN
      key_sr_q    <= key_sr_d;
`endif
    end
  end

  // Display RAM; the read port sees the pre-write byte in a write cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) ram_q[i] <= 8'd0;
      rd_data_q <= 8'd0;
    end else begin
      rd_data_q <= ram_q[ram_rd_addr];
      if (we) ram_q[ptr_q] <= byte_w;
    end
  end

  assign tm_dio_oe     = oe_q;
  assign ram_rd_data   = rd_data_q;
  assign display_on    = on_q;
  assign display_level = level_q;
  assign cmd_valid     = cmd_valid_q;
  assign cmd_byte      = cmd_byte_q;
  assign proto_err     = proto_err_q;

endmodule

// File: tb/tb_tm1638_responder.sv
// Directed bench for tm1638_responder: bus host model, open-drain DIO
// loopback, scoreboard queue for RAM and key-read bytes.
module tb_tm1638_responder;

  localparam logic [2:0] DEF = 3'd5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tm_stb = 1'b1;
  logic tm_clk = 1'b1;
  logic host_dio = 1'b1;
  logic tm_dio_in;
  logic tm_dio_oe;
  logic [7:0] keys = 8'd0;
  logic [3:0] ram_rd_addr = 4'd0;
  logic [7:0] ram_rd_data;
  logic display_on;
  logic [2:0] display_level;
  logic cmd_valid;
  logic [7:0] cmd_byte;
  logic proto_err;

  int checks = 0;
  int errors = 0;
  int cv_cnt = 0;
  int pe_cnt = 0;
  int cv0, pe0;
  logic [11:0] ram_q [$];
  logic [7:0]  key_q [$];

  assign tm_dio_in = host_dio & ~tm_dio_oe;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cmd_valid) cv_cnt <= cv_cnt + 1;
    if (proto_err) pe_cnt <= pe_cnt + 1;
  end

  tm1638_responder #(
    .SYNC_STAGES(2),
    .DEFAULT_LEVEL(DEF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tm_stb(tm_stb),
    .tm_clk(tm_clk),
    .tm_dio_in(tm_dio_in),
    .tm_dio_oe(tm_dio_oe),
    .keys(keys),
    .ram_rd_addr(ram_rd_addr),
    .ram_rd_data(ram_rd_data),
    .display_on(display_on),
    .display_level(display_level),
    .cmd_valid(cmd_valid),
    .cmd_byte(cmd_byte),
    .proto_err(proto_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic gap();
    repeat (10) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      tm_clk = 1'b0;
      host_dio = b[i];
      gap();
      tm_clk = 1'b1;
      gap();
    end
    host_dio = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b, 8);
  endtask

  task automatic stb_low();
    tm_stb = 1'b0;
    gap();
  endtask

  task automatic stb_high();
    tm_stb = 1'b1;
    gap();
  endtask

  task automatic push_ram(input logic [3:0] a, input logic [7:0] d);
    ram_q.push_back({a, d});
  endtask

  task automatic drain_ram(input string tag);
    logic [11:0] e;
    while (ram_q.size() > 0) begin
      e = ram_q.pop_front();
      @(negedge clk);
      ram_rd_addr = e[11:8];
      @(negedge clk);
      chk($sformatf("%s_ram%0d", tag, e[11:8]), {24'd0, ram_rd_data},
          {24'd0, e[7:0]});
    end
  endtask

  task automatic read_bits(input int n, input bit score);
    logic [7:0] rx;
    rx = 8'd0;
    for (int k = 0; k < n; k++) begin
      gap();
      rx[k % 8] = tm_dio_in;
      if (score && (k % 8) == 7) begin
        if (key_q.size() == 0) chk("key_q_empty", 32'd1, 32'd0);
        else chk($sformatf("key_byte%0d", k / 8), {24'd0, rx},
                 {24'd0, key_q.pop_front()});
        rx = 8'd0;
      end
      tm_clk = 1'b0;
      gap();
      tm_clk = 1'b1;
    end
  endtask

  initial begin
    repeat (5) @(negedge clk);
    rst = 1'b0;
    gap();
    chk("rst_oe", {31'd0, tm_dio_oe}, 32'd0);
    chk("rst_on", {31'd0, display_on}, 32'd0);
    chk("rst_level", {29'd0, display_level}, {29'd0, DEF});
    chk("rst_cmd_byte", {24'd0, cmd_byte}, 32'd0);
    chk("rst_cv", cv_cnt, 0);
    chk("rst_pe", pe_cnt, 0);

    cv0 = cv_cnt; pe0 = pe_cnt;
    stb_low(); send_byte(8'h8C); stb_high();
    chk("disp_on", {31'd0, display_on}, 32'd1);
    chk("disp_level", {29'd0, display_level}, 32'd4);
    chk("disp_cmd", {24'd0, cmd_byte}, 32'h8C);
    chk("disp_cv", cv_cnt - cv0, 1);
    chk("disp_pe", pe_cnt - pe0, 0);

    cv0 = cv_cnt;
    stb_low();
    send_byte(8'h40); send_byte(8'hC0);
    send_byte(8'h3F); push_ram(4'd0, 8'h3F);
    send_byte(8'h06); push_ram(4'd1, 8'h06);
    send_byte(8'h5B); push_ram(4'd2, 8'h5B);
    send_byte(8'h4F); push_ram(4'd3, 8'h4F);
    push_ram(4'd4, 8'h00);
    stb_high();
    chk("ai_cmd", {24'd0, cmd_byte}, 32'hC0);
    chk("ai_cv", cv_cnt - cv0, 2);
    drain_ram("ai");

    stb_low();
    send_byte(8'h44); send_byte(8'hCF);
    send_byte(8'h11); send_byte(8'h22);
    stb_high();
    push_ram(4'd15, 8'h22); push_ram(4'd0, 8'h3F);
    drain_ram("fix");
    stb_low();
    send_byte(8'h40); send_byte(8'hCF);
    send_byte(8'hAA); send_byte(8'hBB);
    stb_high();
    push_ram(4'd15, 8'hAA); push_ram(4'd0, 8'hBB);
    drain_ram("wrap");

    pe0 = pe_cnt;
    keys = 8'b1000_0101;
    key_q.push_back(8'h01); key_q.push_back(8'h01);
    key_q.push_back(8'h00); key_q.push_back(8'h10);
    stb_low(); send_byte(8'h42);
    read_bits(32, 1'b1);
    gap();
    chk("rd_oe_end", {31'd0, tm_dio_oe}, 32'd0);
    stb_high();
    chk("rd_pe", pe_cnt - pe0, 0);
    chk("rd_q_left", key_q.size(), 0);

    pe0 = pe_cnt;
    stb_low(); send_byte(8'h00); stb_high();
    chk("c00_pe", pe_cnt - pe0, 1);
    chk("c00_cmd", {24'd0, cmd_byte}, 32'h00);

    pe0 = pe_cnt;
    stb_low();
    send_byte(8'h40); send_byte(8'hC0);
    send_bits(8'hFF, 5);
    stb_high();
    chk("abort_pe", pe_cnt - pe0, 1);
    push_ram(4'd0, 8'hBB);
    drain_ram("abort");
    stb_low(); send_byte(8'h8F); stb_high();
    chk("post_on", {31'd0, display_on}, 32'd1);
    chk("post_level", {29'd0, display_level}, 32'd7);
    chk("post_cmd", {24'd0, cmd_byte}, 32'h8F);

    stb_low(); send_byte(8'h42);
    read_bits(10, 1'b0);
    gap();
    chk("mid_oe_bit10", {31'd0, tm_dio_oe}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_oe", {31'd0, tm_dio_oe}, 32'd0);
    chk("mrst_level", {29'd0, display_level}, {29'd0, DEF});
    chk("mrst_on", {31'd0, display_on}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    stb_high();
    for (int a = 0; a < 16; a++) push_ram(a[3:0], 8'h00);
    drain_ram("mrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
